johnson_synchronous_down_counter: RTL and testbench
===================================================

Name: johnson_synchronous_down_counter

Overview:
Synchronous Johnson (twisted-ring) counter that steps through its ring in the "down" direction, one state per rising clock edge. It has a 4-bit default width and 2*WIDTH legal states. It is a self-contained state generator used as a one-hot-decodable sequencer or phase source. It is self-correcting: any illegal ring pattern returns to the all-zero state on the next edge.

Parameters:
WIDTH, 4, number of flip-flops in the ring (>=2); the count period is 2*WIDTH cycles.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  synchronous active-low reset, sampled on the rising edge of clk; 0 means reset.
out  output WIDTH  current counter state, driven directly from the state register (no combinational path from inputs).

Behaviour:
- Port declaration order is fixed as out, clk, rst, so positional instantiation (out, clk, rst) works.
- Reset:
  - On a rising edge with rst==0, out <= all zeros.
  - Reset has priority over counting and over illegal-state correction.
  - Holding rst low holds out at 0.
  - Deasserting rst mid-count has no effect until the next edge.
  - No asynchronous path; out before the first clock edge is undefined.
- Count step, on a rising edge with rst==1 and a legal current state:
  - out <= {~out[0], out[WIDTH-1:1]}.
  - This is a right shift with the inverted LSB fed into the MSB.
- WIDTH=4 sequence from reset: 0000 -> 1000 -> 1100 -> 1110 -> 1111 -> 0111 -> 0011 -> 0001 -> 0000, then repeats.
  - Period is 8 cycles.
  - Wrap-around from 0001 to 0000 needs no special handling.
- Legal states are exactly the 2*WIDTH patterns of the forms 1^k 0^(WIDTH-k) and 0^k 1^(WIDTH-k), for k=0..WIDTH.
  - Ones contiguous from the MSB, or ones contiguous down to the LSB.
- Illegal state (e.g. 0101, 1001, 0100, 1011 for WIDTH=4), on an edge with rst==1: out <= all zeros.
  - Recovery occurs in exactly one cycle.
  - The normal sequence then resumes from 0000.
- Latency: out reflects the new state one clock after the enabling edge, with zero combinational delay from rst.
- Decoding adjacent states differs in exactly one bit, so consumers can use two-input AND decode (glitch-free).

Decomposition:
- No shared package needed.
- Legality test is a single combinational function or always block inside the module.
- A small sub-module johnson_legal_check (input WIDTH-bit state, output 1-bit legal) is natural if the checker is reused by the up-counting sibling block; otherwise keep it inline.

Test Plan:
1. Hold rst=0 for 2 edges -> out=0000 after the first edge and stays 0000.
2. Release rst=1, run 8 edges -> out=1000,1100,1110,1111,0111,0011,0001,0000; the 9th edge gives 1000 (wrap).
3. Run 36+ edges continuously -> the 8-state sequence repeats with no illegal values, period exactly 8.
4. Assert rst=0 while out=1110 -> out=0000 on that same edge. Release -> next edge 1000.
5. Force state to 0101 (also 1001, 1011) then release with rst=1 -> out=0000 on the next edge, then 1000.
6. WIDTH=3 instance -> sequence 000,100,110,111,011,001,000, period 6.

Source files
------------

// File: rtl/johnson_synchronous_down_counter_pkg.sv
// Shared constants for the Johnson counter family.
//   DEFAULT_WIDTH : ring length used when no override is given
//   MIN_WIDTH     : smallest ring that still forms a twisted ring
package johnson_synchronous_down_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MIN_WIDTH     = 2;

endpackage

// File: rtl/johnson_synchronous_down_counter_if.sv
// Bundles the counter state for consumers that decode it.
// The counter module keeps its plain port list (out, clk, rst) so that
// positional instantiation keeps working. Connect its out port to .state.
//   state  : WIDTH-bit Johnson ring value
//   master : the counter side, which drives state
//   slave  : a decoder side, which reads state
interface johnson_synchronous_down_counter_if
  import johnson_synchronous_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] state;

  modport master (output state);
  modport slave  (input  state);

endinterface

// File: rtl/johnson_synchronous_down_counter_legal_check.sv
// Combinational legality test for a Johnson ring value.
//   state : WIDTH-bit ring value (input)
//   legal : 1 when state is one of the 2*WIDTH ring patterns (output)
// A legal pattern is 1^k 0^(W-k) or 0^k 1^(W-k), which is exactly the set
// of values with at most one change between adjacent bits.
module johnson_legal_check
  import johnson_synchronous_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] state,
  output logic             legal
);

  logic seen;

  always_comb begin
    seen  = 1'b0;
    legal = 1'b1;
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      if (state[i] ^ state[i+1]) begin
        if (seen) legal = 1'b0;
        seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_synchronous_down_counter.sv
// Self-correcting Johnson (twisted-ring) down counter.
//   out : WIDTH-bit counter state, straight from the state register
//   clk : rising-edge clock
//   rst : synchronous active-low reset (0 = reset)
// Sequence for WIDTH=4: 0000,1000,1100,1110,1111,0111,0011,0001, repeat.
// Any illegal ring value is cleared to zero on the next edge.
module johnson_synchronous_down_counter
  import johnson_synchronous_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] state;
  logic             legal;

  johnson_legal_check #(.WIDTH(WIDTH)) u_legal (
    .state (state),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
    end else if (legal) begin
      // right shift, inverted LSB re-enters at the MSB
      state <= {~state[0], state[WIDTH-1:1]};
    end else begin
      state <= '0;
    end
  end

  assign out = state;

endmodule

// File: tb/tb_johnson_synchronous_down_counter.sv
module tb_johnson_synchronous_down_counter;

  logic clk;
  logic rst;
  logic rst3;
  logic [2:0] out3;

  int n_checks = 0;
  int n_fail   = 0;

  johnson_synchronous_down_counter_if #(.WIDTH(4)) cnt_if ();

  johnson_synchronous_down_counter #(.WIDTH(4)) dut (
    .out (cnt_if.state),
    .clk (clk),
    .rst (rst)
  );

  johnson_synchronous_down_counter #(.WIDTH(3)) dut3 (
    .out (out3),
    .clk (clk),
    .rst (rst3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: position p in the ring of a width-w counter.
  // p in 0..w     -> p ones from the MSB
  // p in w+1..2w-1 -> (2w-p) ones at the LSB end
  function automatic logic [7:0] pat(int p, int w);
    int v;
    if (p <= w) v = ((1 << p) - 1) << (w - p);
    else        v = (1 << (2 * w - p)) - 1;
    return 8'(v);
  endfunction

  function automatic int idx_of(logic [7:0] v, int w);
    for (int p = 0; p < 2 * w; p++)
      if (pat(p, w) == v) return p;
    return -1;
  endfunction

  function automatic logic [7:0] model_next(logic [7:0] v, logic r, int w);
    int p;
    if (!r) return 8'd0;
    p = idx_of(v, w);
    if (p < 0) return 8'd0;
    return pat((p + 1) % (2 * w), w);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[15];
  logic [7:0] mv;
  logic [3:0] inj;
  logic [3:0] ill[4];

  initial begin
    rst  = 1'b0;
    rst3 = 1'b0;

    vecs[0]  = '{1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 4'b1000};
    vecs[3]  = '{1'b1, 4'b1100};
    vecs[4]  = '{1'b1, 4'b1110};
    vecs[5]  = '{1'b1, 4'b1111};
    vecs[6]  = '{1'b1, 4'b0111};
    vecs[7]  = '{1'b1, 4'b0011};
    vecs[8]  = '{1'b1, 4'b0001};
    vecs[9]  = '{1'b1, 4'b0000};
    vecs[10] = '{1'b1, 4'b1000};
    vecs[11] = '{1'b1, 4'b1100};
    vecs[12] = '{1'b1, 4'b1110};
    vecs[13] = '{1'b0, 4'b0000};
    vecs[14] = '{1'b1, 4'b1000};

    // table: reset hold, first period, wrap, mid-count reset
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst;
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), {4'b0, cnt_if.state}, {4'b0, vecs[i].exp});
    end

    // long free run against the model, starting from 1000
    mv = 8'b1000;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mv = model_next(mv, 1'b1, 4);
      @(posedge clk);
      #1;
      check("free_run", {4'b0, cnt_if.state}, mv);
    end

    // illegal-state recovery
    ill[0] = 4'b0101; ill[1] = 4'b1001; ill[2] = 4'b1011; ill[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inj = ill[i];
      force dut.state = inj;
      #1;
      release dut.state;
      check("inject_hold", {4'b0, cnt_if.state}, {4'b0, inj});
      @(posedge clk);
      #1;
      check("illegal_clear", {4'b0, cnt_if.state}, 8'd0);
      @(posedge clk);
      #1;
      check("illegal_resume", {4'b0, cnt_if.state}, 8'b1000);
    end

    // randomized reset and injections against the model
    mv = {4'b0, cnt_if.state};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) begin
        inj = 4'($urandom);
        force dut.state = inj;
        #1;
        release dut.state;
        mv = {4'b0, inj};
      end
      mv = model_next(mv, rst, 4);
      @(posedge clk);
      #1;
      check("random", {4'b0, cnt_if.state}, mv);
    end

    // WIDTH=3 instance: reset then 1.5 periods
    rst3 = 1'b0;
    @(posedge clk);
    #1;
    check("w3_reset", {5'b0, out3}, 8'd0);
    rst3 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("w3_seq[%0d]", i), {5'b0, out3}, pat(i % 6, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
